button_encoder_4to2: RTL and testbench
======================================

Name: button_encoder_4to2

Overview:
- Front-panel input block for the stopwatch. It samples four asynchronous, active-low push-buttons (start/stop, lap, reset, mode) and debounces them.
- It encodes a single accepted press into a 2-bit key index with a one-cycle strobe.
- The encoding is the inverse of the display's 2-to-4 active-low select mapping: 1110→0, 1101→1, 1011→2, 0111→3.
- It sits between the board pins and the stopwatch control FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles required for press and release (10 ms at 50 MHz); legal range ≥ 2.
- CNT_W, 20, debounce counter width; must satisfy DEBOUNCE_CYCLES ≤ 2^CNT_W.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_n  input  4  raw buttons, active-low, asynchronous to clk.
- key_code  output  2  index of the last accepted key.
- key_valid  output  1  one-cycle pulse when a key is accepted.
- key_held  output  1  high while the accepted key remains pressed.
- multi_err  output  1  one-cycle pulse when a multi-button press is detected.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: sync stages = 4'b1111, state = IDLE, cnt = 0, candidate = 4'b1111, key_code = 2'b00, key_valid = 0, key_held = 0, multi_err = 0. All outputs are registered.
- Synchronizer: two flops per bit. The FSM uses only the second stage, called pat.
- Pattern classes:
  - REL: pat == 1111.
  - ONE: exactly one bit low.
  - MULTI: two or more bits low.
- IDLE:
  - REL → stay.
  - ONE → DEBOUNCE, candidate = pat, cnt = 0.
  - MULTI → RELEASE, cnt = 0, multi_err pulses.
- DEBOUNCE:
  - pat == candidate and cnt == DEBOUNCE_CYCLES-1 → PRESSED; key_code = encode(candidate), key_valid pulses on the same edge.
  - pat == candidate otherwise → cnt++.
  - REL → IDLE.
  - ONE but different from candidate → candidate = pat, cnt = 0 (restart).
  - MULTI → RELEASE, cnt = 0, multi_err pulses.
- PRESSED:
  - key_held = 1.
  - Any pat ≠ candidate (release, or another key added) → RELEASE, cnt = 0.
  - No further key_valid is issued.
- RELEASE:
  - REL → cnt++; at cnt == DEBOUNCE_CYCLES-1 → IDLE.
  - Any low bit → cnt = 0, stay.
  - No multi_err pulses in this state.
- Latency: with btn_n stable from before edge 0, key_valid is high after rising edge DEBOUNCE_CYCLES+2, i.e. the (DEBOUNCE_CYCLES+3)-th edge. The breakdown is 2 sync + 1 IDLE detect + DEBOUNCE_CYCLES.
- key_code changes only together with key_valid and holds until the next accepted key.
- key_valid and multi_err are exactly 1 cycle wide and never both high.
- key_held drops on the edge leaving PRESSED.
- A minimum of DEBOUNCE_CYCLES stable released cycles is required between two accepted presses.
- A button held through reset deassertion is treated as a fresh press and accepted after full debounce.
- Reset mid-operation clears state and outputs immediately, with no pulse emitted.
- cnt never wraps: it is bounded by DEBOUNCE_CYCLES-1 in every state.

Test Plan:
- DEBOUNCE_CYCLES=4; btn_n=1101 from edge 0, held 20 cycles → single key_valid after edge 6 with key_code=01; key_held=1 until 3 edges after btn_n returns to 1111.
- Bounce: btn_n=1011 for 3 cycles, 1111 for 2, then 1011 held → exactly one key_valid, key_code=10, 7 edges after the last transition.
- Candidate switch: 1110 for 2 cycles then 1101 held → one key_valid with key_code=01, none with 00.
- Multi-press: btn_n=1100 held → one multi_err pulse, no key_valid; then release for ≥4 cycles, then 0111 → key_valid with key_code=11.
- Release glitch: after an accepted 1110, release with 1-cycle 1110 glitches every 3 cycles → no second key_valid; after 4 clean released cycles, pressing 1011 → key_valid with key_code=10.
- Reset: rst_n low for 2 cycles mid-DEBOUNCE → all outputs 0 asynchronously; release rst_n with 1110 held → key_valid with key_code=00 at 7 edges after reset release.

Source files
------------

// File: rtl/button_encoder_4to2.sv
// Debounced 4-button front panel: synchronises active-low buttons and emits a 2-bit key index with a one-cycle strobe.
// Latency: key_valid is high after edge DEBOUNCE_CYCLES+2 of a stable press (2 sync + 1 detect + debounce).
module button_encoder_4to2 #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  output logic [1:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       pat;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [1:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             multi_err_q, multi_err_d;
  logic             pat_rel, pat_one, pat_multi, cnt_last;

  // Inverse of the display's active-low 2-to-4 select mapping.
  function automatic logic [1:0] encode(input logic [3:0] p);
    case (p)
      4'b1110: encode = 2'd0;
      4'b1101: encode = 2'd1;
      4'b1011: encode = 2'd2;
      4'b0111: encode = 2'd3;
      default: encode = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign pat       = sync2_q;
  assign pat_rel   = &pat;
  assign pat_one   = $onehot(~pat);
  assign pat_multi = !pat_rel && !pat_one;
  assign cnt_last  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'b1111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: begin
        if (pat_one) begin
          state_d = DEBOUNCE;
          cand_d  = pat;
          cnt_d   = '0;
        end else if (pat_multi) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (pat == cand_q) begin
          if (cnt_last) state_d = PRESSED;
          else          cnt_d   = cnt_q + 1'b1;
        end else if (pat_rel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pat_one) begin
          cand_d = pat;
          cnt_d  = '0;
        end else begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (pat != cand_q) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        // Any low bit restarts the quiet period, so a new press needs a full clean release first.
        if (!pat_rel) begin
          cnt_d = '0;
        end else if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    key_valid_d = (state_q == DEBOUNCE) && (state_d == PRESSED);
    multi_err_d = ((state_q == IDLE) || (state_q == DEBOUNCE)) && pat_multi;
    key_held_d  = (state_d == PRESSED);
    key_code_d  = key_valid_d ? encode(cand_q) : key_code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_q  <= 2'b00;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_err = multi_err_q;

endmodule

// File: tb/tb_button_encoder_4to2.sv
// Scoreboard bench for button_encoder_4to2 with a short debounce window.
module tb_button_encoder_4to2;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_n = 4'b1111;
  logic [1:0] key_code;
  logic       key_valid, key_held, multi_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t kq[$];
  int   mq[$];

  button_encoder_4to2 #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_n    (btn_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_err(multi_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive a pattern at the current negedge and hold it for n cycles.
  // A key press accepted from this pattern must strobe on the 7th edge after the change,
  // a multi-press error on the 3rd edge.
  task automatic hold(input logic [3:0] p, input int n, input int code, input bit merr);
    btn_n = p;
    if (code >= 0) kq.push_back('{code: code, cyc: cyc + DC + 3});
    if (merr) mq.push_back(cyc + 3);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid || multi_err) check("excl", int'(key_valid & multi_err), 0);
      if (key_valid) begin
        if (kq.size() == 0) begin
          check("kv_spurious", 1, 0);
        end else begin
          exp_t e;
          e = kq.pop_front();
          check("kv_code", int'(key_code), e.code);
          check("kv_cyc", cyc, e.cyc);
          check("kv_held", int'(key_held), 1);
        end
      end
      if (multi_err) begin
        if (mq.size() == 0) check("me_spurious", 1, 0);
        else                check("me_cyc", cyc, mq.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_code", int'(key_code), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);
    check("rst_merr", int'(multi_err), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press of key 1, then release timing of key_held
    hold(4'b1101, 20, 1, 0);
    check("t1_held", int'(key_held), 1);
    check("t1_code", int'(key_code), 1);
    hold(4'b1111, 2, -1, 0);
    check("t1_held_still", int'(key_held), 1);
    hold(4'b1111, 1, -1, 0);
    check("t1_held_drop", int'(key_held), 0);
    hold(4'b1111, 8, -1, 0);

    // Bounce on key 2
    hold(4'b1011, 3, -1, 0);
    hold(4'b1111, 2, -1, 0);
    hold(4'b1011, 15, 2, 0);
    check("t2_code", int'(key_code), 2);
    hold(4'b1111, 10, -1, 0);

    // Candidate switch 0 -> 1
    hold(4'b1110, 2, -1, 0);
    hold(4'b1101, 15, 1, 0);
    check("t3_code", int'(key_code), 1);
    hold(4'b1111, 10, -1, 0);

    // Multi-press then key 3
    hold(4'b1100, 12, -1, 1);
    check("t4_held", int'(key_held), 0);
    check("t4_code_kept", int'(key_code), 1);
    hold(4'b1111, 6, -1, 0);
    hold(4'b0111, 12, 3, 0);
    check("t4_code", int'(key_code), 3);
    hold(4'b1111, 10, -1, 0);

    // Release glitches must not produce a second press
    hold(4'b1110, 12, 0, 0);
    for (int i = 0; i < 4; i++) begin
      hold(4'b1111, 2, -1, 0);
      hold(4'b1110, 1, -1, 0);
    end
    hold(4'b1111, 4, -1, 0);
    check("t5_code_kept", int'(key_code), 0);
    hold(4'b1011, 12, 2, 0);
    check("t5_code", int'(key_code), 2);
    hold(4'b1111, 10, -1, 0);

    // Reset mid-debounce, then a key held through reset release
    hold(4'b1101, 3, -1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_code", int'(key_code), 0);
    check("t6_rst_valid", int'(key_valid), 0);
    check("t6_rst_held", int'(key_held), 0);
    check("t6_rst_merr", int'(multi_err), 0);
    btn_n = 4'b1110;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(4'b1110, 12, 0, 0);
    check("t6_held", int'(key_held), 1);
    check("t6_code", int'(key_code), 0);
    hold(4'b1111, 10, -1, 0);

    check("kv_pending", kq.size(), 0);
    check("me_pending", mq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
